// File: rtl/elf_keypad_pkg.sv
// Shared constants for the ELF keypad front end: PS/2 set-2 scancodes and IN-button FSM state.
package elf_keypad_pkg;

  localparam logic [7:0] ScEnter = 8'h5A;
  localparam logic [7:0] ScBksp  = 8'h66;
  localparam logic [7:0] ScLoad  = 8'h4B;
  localparam logic [7:0] ScRun   = 8'h2D;
  localparam logic [7:0] ScMp    = 8'h3A;

  // Index i holds the scancode of hex digit i.
  localparam logic [15:0][7:0] HexCodes = {
    8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C, 8'h46, 8'h3E,
    8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  typedef enum logic [1:0] {
    InIdle    = 2'd0,
    InHeld    = 2'd1,
    InStretch = 2'd2
  } in_state_e;

endpackage

// File: rtl/elf_scan_decode.sv
// Combinational scancode classifier: hex digit value plus the ELF control keys.
module elf_scan_decode
  import elf_keypad_pkg::*;
(
  input  logic [7:0] scancode,
  output logic       is_hex,
  output logic [3:0] digit,
  output logic       is_bksp,
  output logic       is_enter,
  output logic       is_load,
  output logic       is_run,
  output logic       is_mp
);

  always_comb begin
    is_hex = 1'b0;
    digit  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (scancode == HexCodes[i]) begin
        is_hex = 1'b1;
        digit  = 4'(i);
      end
    end
    is_bksp  = (scancode == ScBksp);
    is_enter = (scancode == ScEnter);
    is_load  = (scancode == ScLoad);
    is_run   = (scancode == ScRun);
    is_mp    = (scancode == ScMp);
  end

endmodule

// File: rtl/elf_keypad.sv
// PS/2 keyboard to COSMAC ELF front panel: data switches, LOAD/RUN/MP toggles and a
// minimum-width IN button pulse.
module elf_keypad
  import elf_keypad_pkg::*;
#(
  parameter int unsigned IN_HOLD = 48000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  output logic [7:0]  data_sw,
  output logic        in_btn,
  output logic        load_sw,
  output logic        run_sw,
  output logic        mp_sw,
  output logic        key_evt
);

  localparam int unsigned CntW = $clog2(IN_HOLD) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(IN_HOLD - 1);

  logic            strobe_q, primed_q;
  logic [7:0]      data_q;
  logic            load_q, run_q, mp_q, evt_q, in_btn_q;
  in_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       is_hex, is_bksp, is_enter, is_load, is_run, is_mp;
  logic [3:0] digit;

  elf_scan_decode u_decode (
    .scancode (ps2_key[7:0]),
    .is_hex   (is_hex),
    .digit    (digit),
    .is_bksp  (is_bksp),
    .is_enter (is_enter),
    .is_load  (is_load),
    .is_run   (is_run),
    .is_mp    (is_mp)
  );

  // Strobe toggles mark new keyboard events; the first cycle after reset only primes the copy.
  logic evt, press, release_evt, mapped, enter_press, enter_rel;

  always_comb begin
    evt         = primed_q & (ps2_key[10] ^ strobe_q) & ~ps2_key[8];
    press       = evt & ps2_key[9];
    release_evt = evt & ~ps2_key[9];
    mapped      = is_hex | is_bksp | is_enter | is_load | is_run | is_mp;
    enter_press = press & is_enter;
    enter_rel   = release_evt & is_enter;
  end

  // IN button: held while Enter is down, stretched afterwards to at least IN_HOLD cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      InIdle: begin
        if (enter_press) begin
          state_d = InHeld;
          cnt_d   = CntLoad;
        end
      end
      InHeld: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        if (enter_rel) state_d = InStretch;
      end
      InStretch: begin
        if (enter_press) begin
          state_d = InHeld;
          cnt_d   = CntLoad;
        end else if (cnt_q == '0) begin
          state_d = InIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = InIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      primed_q <= 1'b0;
      data_q   <= 8'h00;
      load_q   <= 1'b0;
      run_q    <= 1'b0;
      mp_q     <= 1'b0;
      evt_q    <= 1'b0;
      in_btn_q <= 1'b0;
      state_q  <= InIdle;
      cnt_q    <= '0;
    end else begin
      strobe_q <= ps2_key[10];
      primed_q <= 1'b1;
      evt_q    <= press & mapped;
      if (press) begin
        if (is_hex) data_q <= {data_q[3:0], digit};
        else if (is_bksp) data_q <= 8'h00;
        if (is_load) load_q <= ~load_q;
        if (is_run) run_q <= ~run_q;
        if (is_mp) mp_q <= ~mp_q;
      end
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_btn_q <= (state_d != InIdle);
    end
  end

  assign data_sw = data_q;
  assign load_sw = load_q;
  assign run_sw  = run_q;
  assign mp_sw   = mp_q;
  assign key_evt = evt_q;
  assign in_btn  = in_btn_q;

endmodule

// File: tb/tb_elf_keypad.sv
// Directed bench for elf_keypad with IN_HOLD = 8.
module tb_elf_keypad;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [7:0]  data_sw;
  logic        in_btn, load_sw, run_sw, mp_sw, key_evt;

  elf_keypad #(
    .IN_HOLD (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .data_sw (data_sw),
    .in_btn  (in_btn),
    .load_sw (load_sw),
    .run_sw  (run_sw),
    .mp_sw   (mp_sw),
    .key_evt (key_evt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int evt_seen = 0;
  logic tgl;

  always @(negedge clk) if (key_evt === 1'b1) evt_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic pr, input logic ext, input logic [7:0] code);
    tgl     = ~tgl;
    ps2_key = {tgl, pr, ext, code};
  endtask

  // Press then release one key, checking the data byte and the press pulse.
  task automatic tap(input string tag, input logic [7:0] code, input logic [7:0] exp_data,
                     input logic exp_evt);
    @(negedge clk);
    send(1'b1, 1'b0, code);
    @(negedge clk);
    check({tag, "_data"}, {24'h0, data_sw}, {24'h0, exp_data});
    check({tag, "_evt"}, {31'h0, key_evt}, {31'h0, exp_evt});
    send(1'b0, 1'b0, code);
    @(negedge clk);
    check({tag, "_rel"}, {24'h0, data_sw}, {24'h0, exp_data});
  endtask

  // Enter press, then Enter events at the given sample indices (-1 disables); counts in_btn.
  task automatic in_run(input int rel_at, input int ex_at, input logic ex_pr, input int rel2_at,
                        output int high, output int high_after_ex);
    @(negedge clk);
    send(1'b1, 1'b0, 8'h5A);
    high = 0;
    high_after_ex = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_btn !== 1'b1) break;
      high++;
      if (ex_at >= 0 && i > ex_at) high_after_ex++;
      if (i == rel_at) send(1'b0, 1'b0, 8'h5A);
      if (i == ex_at) send(ex_pr, 1'b0, 8'h5A);
      if (i == rel2_at) send(1'b0, 1'b0, 8'h5A);
    end
  endtask

  initial begin
    int base, high, after, hits;
    tgl     = 1'b1;
    ps2_key = {1'b1, 10'h000};
    reset_n = 1'b0;
    #12;
    check("rst_data", {24'h0, data_sw}, 32'h0);
    check("rst_in", {31'h0, in_btn}, 32'h0);
    check("rst_sw", {29'h0, load_sw, run_sw, mp_sw}, 32'h0);
    check("rst_evt", {31'h0, key_evt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    base = evt_seen;
    repeat (6) @(negedge clk);
    check("prime_noevt", evt_seen - base, 32'd0);
    check("prime_outs", {23'h0, data_sw, in_btn}, 32'h0);

    // Hex entry and backspace.
    base = evt_seen;
    tap("d1", 8'h16, 8'h01, 1'b1);
    tap("d2", 8'h1E, 8'h12, 1'b1);
    tap("d3", 8'h26, 8'h23, 1'b1);
    check("three_evts", evt_seen - base, 32'd3);
    tap("bksp", 8'h66, 8'h00, 1'b1);
    tap("dA", 8'h1C, 8'h0A, 1'b1);
    tap("dF", 8'h2B, 8'hAF, 1'b1);
    tap("d0", 8'h45, 8'hF0, 1'b1);
    tap("unmapped", 8'h15, 8'hF0, 1'b0);

    // Consecutive-cycle strobe toggles are each processed.
    @(negedge clk);
    send(1'b1, 1'b0, 8'h3D);
    @(negedge clk);
    send(1'b1, 1'b0, 8'h46);
    @(negedge clk);
    check("b2b_data", {24'h0, data_sw}, 32'h79);
    check("b2b_evt", {31'h0, key_evt}, 32'h1);

    // Panel switches; extended R is ignored.
    tap("r1", 8'h2D, 8'h79, 1'b1);
    check("run_on", {31'h0, run_sw}, 32'h1);
    tap("r2", 8'h2D, 8'h79, 1'b1);
    check("run_off", {31'h0, run_sw}, 32'h0);
    tap("m1", 8'h3A, 8'h79, 1'b1);
    check("mp_on", {31'h0, mp_sw}, 32'h1);
    @(negedge clk);
    send(1'b1, 1'b1, 8'h2D);
    @(negedge clk);
    check("ext_evt", {31'h0, key_evt}, 32'h0);
    @(negedge clk);
    check("ext_run", {31'h0, run_sw}, 32'h0);
    tap("l1", 8'h4B, 8'h79, 1'b1);
    check("sw_state", {29'h0, load_sw, run_sw, mp_sw}, 32'b101);

    // Enter release while idle does nothing.
    @(negedge clk);
    send(1'b0, 1'b0, 8'h5A);
    repeat (2) @(negedge clk);
    check("idle_rel", {31'h0, in_btn}, 32'h0);

    // Short hold is stretched to IN_HOLD; long hold follows the key.
    base = evt_seen;
    in_run(1, -1, 1'b0, -1, high, after);
    check("in_short", high, 32'd8);
    check("enter_evt", evt_seen - base, 32'd1);
    in_run(18, -1, 1'b0, -1, high, after);
    check("in_long", high, 32'd20);
    in_run(18, 5, 1'b1, -1, high, after);
    check("in_held_press", high, 32'd20);
    in_run(1, 3, 1'b1, 5, high, after);
    check("in_repress", high, 32'd12);
    check("in_repress_tail", after, 32'd8);

    // Reset during STRETCH drops in_btn at once and leaves no tail.
    @(negedge clk);
    send(1'b1, 1'b0, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    send(1'b0, 1'b0, 8'h5A);
    repeat (2) @(negedge clk);
    check("stretch_pre", {31'h0, in_btn}, 32'h1);
    #2 reset_n = 1'b0;
    #1 check("rst_async_in", {31'h0, in_btn}, 32'h0);
    check("rst_async_sw", {21'h0, data_sw, load_sw, run_sw, mp_sw}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (in_btn !== 1'b0) hits++;
    end
    check("rst_no_tail", hits, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
